// File: rtl/inst_loader.sv
// Serial program loader: streams a length-prefixed byte image into instruction memory.
// Optional `LOADER_CHECKSUM_EN adds an XOR checksum byte that is verified after the data.
module inst_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [2:0]        state_dbg
);
    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // the source keeps byte_in stable while byte_valid=1 and byte_ready=0.

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_AFTER = S_CHK;
`else
    localparam logic [2:0] S_AFTER = S_DONE;
`endif

    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    logic [2:0]      state;
    logic [2:0]      next_state;
    logic [15:0]     len;
    logic [15:0]     len_full;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] idx_inc;
    logic [1:0]      byte_cnt;
    logic [23:0]     word;
    logic            xfer;
    logic            rdy_next;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign state_dbg = state;

    always_comb begin
        next_state = state;
        xfer       = byte_valid && byte_ready;
        len_full   = {byte_in, len[7:0]};
        idx_inc    = index + 1'b1;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN0;
            S_LEN0: if (xfer) next_state = S_LEN1;
            S_LEN1: begin
                if (xfer) begin
                    if ({1'b0, len_full} > MAX_LEN) next_state = S_ERR;
                    else if (len_full == 16'd0)     next_state = S_AFTER;
                    else                            next_state = S_DATA;
                end
            end
            S_DATA: if (xfer && byte_cnt == 2'd3) next_state = S_WRITE;
            S_WRITE: begin
                if (17'(idx_inc) == {1'b0, len}) next_state = S_AFTER;
                else                             next_state = S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (xfer) next_state = (byte_in == csum) ? S_DONE : S_ERR;
`endif
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_comb begin
        rdy_next = (next_state == S_LEN0) || (next_state == S_LEN1) || (next_state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
        if (next_state == S_CHK) rdy_next = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            len         <= '0;
            index       <= '0;
            byte_cnt    <= '0;
            word        <= '0;
            byte_ready  <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cpu_hold    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            state      <= next_state;
            byte_ready <= rdy_next;
            mem_wr_en  <= (next_state == S_WRITE);
            cpu_hold   <= !((next_state == S_IDLE) || (next_state == S_DONE));
            done       <= (next_state == S_DONE);
            error      <= (next_state == S_ERR);
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        index    <= '0;
                        byte_cnt <= '0;
                        len      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN0: if (xfer) len[7:0] <= byte_in;
                S_LEN1: if (xfer) len[15:8] <= byte_in;
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_in;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_wr_data <= {byte_in, word};
                            mem_addr    <= index[ADDR_W-1:0];
                        end else begin
                            word[{byte_cnt, 3'b000} +: 8] <= byte_in;
                        end
                    end
                end
                S_WRITE: index <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: table-driven sessions plus hand-written corner cases.
module tb_inst_loader;
    localparam int ADDR_W = 10;
    localparam int W = ADDR_W + 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [2:0]        state_dbg;

    logic [W-1:0] exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_wr_cyc = -1;
    bit  check_gap = 1'b0;
    logic [7:0] chk_acc;

    typedef struct {
        logic [15:0] len;
        logic [31:0] word0;
        bit          bp;
        bit          exp_err;
    } vec_t;
    vec_t vecs[6];

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .cpu_hold(cpu_hold),
        .done(done), .error(error), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every write strobe pops one expected {addr, data}
    always @(negedge clock) begin
        cyc++;
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wr_data);
            end else begin
                check("write", 64'({mem_addr, mem_wr_data}), 64'(exp_q.pop_front()));
            end
            if (check_gap && last_wr_cyc >= 0)
                check("write_gap", 64'(cyc - last_wr_cyc), 64'd5);
            last_wr_cyc = cyc;
        end
    end

    // driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bp);
        int n = 0;
        if (bp) begin
            byte_valid = 1'b0;
            @(posedge clock); #1;
        end
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte: byte_ready stuck at 0, expected 1");
        end
        @(posedge clock); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input int k, input logic [31:0] w, input bit bp, input int start_at);
        logic [ADDR_W-1:0] a;
        logic [7:0] b;
        a = ADDR_W'(k);
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            chk_acc = chk_acc ^ b;
            if (i == 3) exp_q.push_back({a, w});
            if (i == start_at) start = 1'b1;
            send_byte(b, bp);
            start = 1'b0;
        end
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_end: done=%0b error=%0b after 200 cycles, expected one set", done, error);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wr_data"}, 64'(mem_wr_data), 64'd0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        logic [31:0] w;
        last_wr_cyc = -1;
        check_gap = !v.bp && (v.len > 16'd1);
        chk_acc = 8'h00;
        pulse_start();
        check($sformatf("v%0d_start_error", vi), 64'(error), 64'd0);
        check($sformatf("v%0d_start_done", vi), 64'(done), 64'd0);
        check($sformatf("v%0d_start_hold", vi), 64'(cpu_hold), 64'd1);
        check($sformatf("v%0d_start_ready", vi), 64'(byte_ready), 64'd1);
        send_byte(v.len[7:0], v.bp);
        send_byte(v.len[15:8], v.bp);
        if (!v.exp_err) begin
            for (int k = 0; k < int'(v.len); k++) begin
                w = (k == 0) ? v.word0 : $urandom();
                send_word(k, w, v.bp, -1);
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(chk_acc, v.bp);
`endif
        end
        wait_end();
        check($sformatf("v%0d_done", vi), 64'(done), 64'(!v.exp_err));
        check($sformatf("v%0d_error", vi), 64'(error), 64'(v.exp_err));
        check($sformatf("v%0d_cpu_hold", vi), 64'(cpu_hold), 64'(v.exp_err));
        check($sformatf("v%0d_ready", vi), 64'(byte_ready), 64'd0);
        check($sformatf("v%0d_writes_left", vi), 64'(exp_q.size()), 64'd0);
        check_gap = 1'b0;
    endtask

    initial begin
        vecs[0] = '{len: 16'd1,    word0: 32'h20000821, bp: 1'b0, exp_err: 1'b0};
        vecs[1] = '{len: 16'd3,    word0: 32'h12345678, bp: 1'b1, exp_err: 1'b0};
        vecs[2] = '{len: 16'h0401, word0: 32'h0,        bp: 1'b0, exp_err: 1'b1};
        vecs[3] = '{len: 16'd0,    word0: 32'h0,        bp: 1'b0, exp_err: 1'b0};
        vecs[4] = '{len: 16'd4,    word0: 32'hCAFEF00D, bp: 1'b0, exp_err: 1'b0};
        vecs[5] = '{len: 16'd1024, word0: 32'hA5A5A5A5, bp: 1'b0, exp_err: 1'b0};

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_idle_outputs("reset");
        reset = 1'b1;
        @(posedge clock); #1;
        check_idle_outputs("idle");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // start pulsed while in DATA must be ignored
        chk_acc = 8'h00;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(0, 32'h0BADBEEF, 1'b0, 2);
        send_word(1, 32'h76543210, 1'b0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(chk_acc, 1'b0);
`endif
        wait_end();
        check("ign_start_done", 64'(done), 64'd1);
        check("ign_start_writes_left", 64'(exp_q.size()), 64'd0);

        // reset in the middle of word 1: only word 0 is written
        chk_acc = 8'h00;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(0, 32'h11223344, 1'b0, -1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check_idle_outputs("after_midreset");
        check("midreset_writes_left", 64'(exp_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
        // checksum match then mismatch on the same word
        for (int t = 0; t < 2; t++) begin
            chk_acc = 8'h00;
            pulse_start();
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            send_word(0, 32'hDDCCBBAA, 1'b0, -1);
            send_byte((t == 0) ? 8'h00 : 8'h01, 1'b0);
            wait_end();
            check($sformatf("csum%0d_done", t), 64'(done), 64'(t == 0));
            check($sformatf("csum%0d_error", t), 64'(error), 64'(t == 1));
            check($sformatf("csum%0d_writes_left", t), 64'(exp_q.size()), 64'd0);
        end
`endif

        repeat (3) @(posedge clock);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
